// File: rtl/regfile_sb.sv
// Integer register file with two registered read ports, one write port,
// optional write-first bypass and a busy-bit scoreboard with population count.
// x0 is never written and never marked busy, so it always reads as zero.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1data,
    output logic [XLEN-1:0] rs2data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rddata,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic [AW:0]     busy_cnt
);

    localparam int NREG = 1 << AW;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] rsdata_q [2];
    logic [XLEN-1:0] rsdata_d [2];
    logic [1:0]      rsbusy_q, rsbusy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;
    logic [AW-1:0]   rs_idx [2];
    logic            wr_ok, iss_ok, set_ev, clr_ev, fwd;

    assign rs_idx[0] = rs1;
    assign rs_idx[1] = rs2;

    // Array/scoreboard update: write clears busy, a same-cycle issue re-sets it.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        wr_ok  = we && (rd != '0);
        iss_ok = iss_valid && (iss_rd != '0);
        if (wr_ok) begin
            regs_d[rd] = rddata;
            busy_d[rd] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    // Population count kept incrementally; at most one set and one clear per cycle.
    always_comb begin
        set_ev     = iss_ok && !busy_q[iss_rd];
        clr_ev     = wr_ok && busy_q[rd] && !(iss_ok && (iss_rd == rd));
        busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, set_ev} - {{AW{1'b0}}, clr_ev};
    end

    // Read ports: x0 forced to zero, optional forwarding of the in-flight write.
    always_comb begin
        rsdata_d = rsdata_q;
        rsbusy_d = rsbusy_q;
        fwd      = 1'b0;
        if (rd_en) begin
            for (int p = 0; p < 2; p++) begin
                fwd = (BYPASS != 0) && we && (rd == rs_idx[p]);
                if (rs_idx[p] == '0) begin
                    rsdata_d[p] = '0;
                    rsbusy_d[p] = 1'b0;
                end else if (fwd) begin
                    rsdata_d[p] = rddata;
                    rsbusy_d[p] = 1'b0;
                end else begin
                    rsdata_d[p] = regs_q[rs_idx[p]];
                    rsbusy_d[p] = busy_q[rs_idx[p]];
                end
            end
        end
    end

    // State registers; clr overrides every other input.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            rsdata_q[0] <= '0;
            rsdata_q[1] <= '0;
            rsbusy_q    <= '0;
            busy_cnt_q  <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            regs_q[0]   <= '0;
            busy_q      <= {busy_d[NREG-1:1], 1'b0};
            rsdata_q[0] <= rsdata_d[0];
            rsdata_q[1] <= rsdata_d[1];
            rsbusy_q    <= rsbusy_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign rs1data  = rsdata_q[0];
    assign rs2data  = rsdata_q[1];
    assign rs1_busy = rsbusy_q[0];
    assign rs2_busy = rsbusy_q[1];
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; a write-first and a read-old instance share stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        clr, rd_en, we, iss_valid;
    logic [4:0]  rs1, rs2, rd, iss_rd;
    logic [31:0] rddata;

    logic [31:0] b_rs1data, b_rs2data, n_rs1data, n_rs2data;
    logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic [5:0]  b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(32), .AW(5), .BYPASS(1)) u_dut (
        .clk(clk), .clr(clr), .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
        .rs1data(b_rs1data), .rs2data(b_rs2data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .we(we), .rd(rd), .rddata(rddata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(b_cnt)
    );

    regfile_sb #(.XLEN(32), .AW(5), .BYPASS(0)) u_nb (
        .clk(clk), .clr(clr), .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
        .rs1data(n_rs1data), .rs2data(n_rs2data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .we(we), .rd(rd), .rddata(rddata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; rd_en = 1'b0; we = 1'b0; iss_valid = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; iss_rd = '0; rddata = '0;
    endtask

    initial begin
        idle();
        clr = 1'b1;
        tick(); tick();
        idle();
        chk("rst_rs1data", b_rs1data, 0);
        chk("rst_rs2data", b_rs2data, 0);
        chk("rst_rs1busy", b_rs1_busy, 0);
        chk("rst_rs2busy", b_rs2_busy, 0);
        chk("rst_cnt", b_cnt, 0);

        // preload x5 and busy[5] (same-cycle write + issue -> busy stays set)
        we = 1; rd = 5; rddata = 32'hDEADBEEF; iss_valid = 1; iss_rd = 5;
        tick(); idle();
        chk("preload_cnt", b_cnt, 1);
        rd_en = 1; rs1 = 5;
        tick(); idle();
        chk("preload_data", b_rs1data, 32'hDEADBEEF);
        chk("preload_busy", b_rs1_busy, 1);

        // clear while other inputs are active
        clr = 1; we = 1; rd = 5; rddata = 32'h123; iss_valid = 1; iss_rd = 6; rd_en = 1; rs1 = 5;
        tick(); idle();
        chk("clr_rs1data", b_rs1data, 0);
        chk("clr_rs1busy", b_rs1_busy, 0);
        chk("clr_cnt", b_cnt, 0);
        rd_en = 1; rs1 = 5; rs2 = 6;
        tick(); idle();
        chk("clr_x5", b_rs1data, 0);
        chk("clr_busy5", b_rs1_busy, 0);
        chk("clr_busy6", b_rs2_busy, 0);

        // x0 is never written or marked busy
        we = 1; rd = 0; rddata = 32'hFFFFFFFF; rd_en = 1; rs1 = 0; rs2 = 0;
        tick(); idle();
        chk("x0_byp_rs1", b_rs1data, 0);
        chk("x0_byp_rs2", b_rs2data, 0);
        rd_en = 1; rs1 = 0; rs2 = 0; iss_valid = 1; iss_rd = 0;
        tick(); idle();
        chk("x0_rs1", b_rs1data, 0);
        chk("x0_rs2", n_rs2data, 0);
        chk("x0_busy", b_rs1_busy, 0);
        chk("x0_iss_cnt", b_cnt, 0);

        // bypass vs read-old
        we = 1; rd = 7; rddata = 32'h1;
        tick(); idle();
        we = 1; rd = 7; rddata = 32'h12345678; rd_en = 1; rs1 = 7; rs2 = 7;
        tick(); idle();
        chk("byp_rs1", b_rs1data, 32'h12345678);
        chk("byp_rs2", b_rs2data, 32'h12345678);
        chk("nb_rs1_old", n_rs1data, 32'h1);
        chk("nb_rs2_old", n_rs2data, 32'h1);
        rd_en = 1; rs1 = 7; rs2 = 7;
        tick(); idle();
        chk("nb_rs1_new", n_rs1data, 32'h12345678);

        // scoreboard: same-cycle issue is not in the snapshot
        iss_valid = 1; iss_rd = 3; rd_en = 1; rs1 = 3;
        tick(); idle();
        chk("sb_snap_same", b_rs1_busy, 0);
        chk("sb_cnt1a", b_cnt, 1);
        rd_en = 1; rs1 = 3;
        tick(); idle();
        chk("sb_busy3", b_rs1_busy, 1);
        chk("sb_cnt1b", b_cnt, 1);
        we = 1; rd = 3; rddata = 32'hA5; rd_en = 1; rs1 = 3;
        tick(); idle();
        chk("sb_wr_data", b_rs1data, 32'hA5);
        chk("sb_wr_busy", b_rs1_busy, 0);
        chk("sb_wr_cnt", b_cnt, 0);
        chk("nb_wr_data", n_rs1data, 0);
        chk("nb_wr_busy", n_rs1_busy, 1);
        chk("nb_wr_cnt", n_cnt, 0);

        // collision: write and issue of x9 in the same cycle
        iss_valid = 1; iss_rd = 9;
        tick(); idle();
        chk("col_cnt_pre", b_cnt, 1);
        we = 1; rd = 9; rddata = 32'h55; iss_valid = 1; iss_rd = 9;
        tick(); idle();
        chk("col_cnt", b_cnt, 1);
        rd_en = 1; rs1 = 9; rs2 = 9;
        tick(); idle();
        chk("col_data", b_rs1data, 32'h55);
        chk("col_busy", b_rs2_busy, 1);
        iss_valid = 1; iss_rd = 4;
        tick(); idle();
        chk("iss4_cnt", b_cnt, 2);
        iss_valid = 1; iss_rd = 4;
        tick(); idle();
        chk("iss4_twice_cnt", b_cnt, 2);
        // set x10 and release x9 in the same cycle -> net zero
        iss_valid = 1; iss_rd = 10; we = 1; rd = 9; rddata = 32'h66;
        tick(); idle();
        chk("set_clr_cnt", b_cnt, 2);
        we = 1; rd = 11; rddata = 32'h77;
        tick(); idle();
        chk("clr_idle_cnt", b_cnt, 2);
        rd_en = 1; rs1 = 4; rs2 = 9;
        tick(); idle();
        chk("rd4_busy", b_rs1_busy, 1);
        chk("rd9_busy", b_rs2_busy, 0);
        chk("rd9_data", n_rs2data, 32'h66);

        // hold: rd_en low, random writes must not disturb outputs
        for (int i = 0; i < 8; i++) begin
            we = 1; rd = 5'($urandom_range(31, 1)); rddata = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            tick();
            chk("hold_rs1data", b_rs1data, 0);
            chk("hold_rs1busy", b_rs1_busy, 1);
            chk("hold_rs2data", b_rs2data, 32'h66);
            chk("hold_rs2busy", b_rs2_busy, 0);
        end
        idle();

        // fill the scoreboard
        clr = 1;
        tick(); idle();
        for (int r = 1; r < 32; r++) begin
            iss_valid = 1; iss_rd = 5'(r);
            tick();
        end
        idle();
        chk("full_cnt", b_cnt, 31);
        iss_valid = 1; iss_rd = 5; rd_en = 1; rs1 = 31; rs2 = 1;
        tick(); idle();
        chk("full_no_wrap", b_cnt, 31);
        chk("full_busy31", b_rs1_busy, 1);
        chk("full_busy1", b_rs2_busy, 1);

        // clear in the middle of a write
        we = 1; rd = 12; rddata = 32'hABC; clr = 1;
        tick(); idle();
        chk("mid_clr_cnt", b_cnt, 0);
        chk("mid_clr_rs1busy", b_rs1_busy, 0);
        chk("mid_clr_rs2busy", b_rs2_busy, 0);
        rd_en = 1; rs1 = 12; rs2 = 31;
        tick(); idle();
        chk("mid_clr_x12", b_rs1data, 0);
        chk("mid_clr_busy31", b_rs2_busy, 0);
        chk("mid_clr_nb_cnt", n_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
